// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one byte per UART_Enable, LSB first, registered tx pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_Enable,
  input  logic [7:0] data_UART,
  output logic       UART_busy,
  output logic       tx,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: baud counter, bit index and shifter advance at bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (UART_Enable) begin
          state_d = S_START;
          bit_d   = '0;
          shift_d = data_UART;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_UART;
`endif
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight off flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign UART_busy = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: CLKS_PER_BIT=4 main instance, CLKS_PER_BIT=2 side instance.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, tx, done;
  logic       en2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic       busy2, tx2, done2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst(rst), .UART_Enable(en), .data_UART(din),
    .UART_busy(busy), .tx(tx), .tx_done(done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .UART_Enable(en2), .data_UART(din2),
    .UART_busy(busy2), .tx(tx2), .tx_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // frame: bit i = i-th serial bit (start, d0..d7, stop); par = hand-computed even parity.
  // mode 0 plain, 1 disturb mid-frame, 2 hold enable through done, 4 reset at E+17.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [9:0] frame,
                           input logic par, input int mode);
    logic exp_tx;
    int   b;
    din = d;
    en  = 1'b1;
    chk({name, "_busy_pre"}, busy, 1'b0);
    step();
    if (mode != 2) en = 1'b0;
    for (int n = 0; n <= NB*CPB; n++) begin
      if (n < NB*CPB) begin
        b = n / CPB;
        if (b < 9) exp_tx = frame[b];
        else if (NB == 11 && b == 9) exp_tx = par;
        else exp_tx = 1'b1;
        chk($sformatf("%s_tx%0d", name, n), tx, exp_tx);
        chk($sformatf("%s_busy%0d", name, n), busy, 1'b1);
        chk($sformatf("%s_done%0d", name, n), done, 1'b0);
      end else begin
        chk({name, "_done_tx"}, tx, 1'b1);
        chk({name, "_done_busy"}, busy, 1'b0);
        chk({name, "_done_pulse"}, done, 1'b1);
      end
      if (mode == 1 && n == 8)  begin en = 1'b1; din = 8'h0A; end
      if (mode == 1 && n == 9)  en = 1'b0;
      if (mode == 1 && n == 17) din = 8'hFF;
      if (mode == 4 && n == 17) begin
        rst = 1'b0;
        step();
        chk({name, "_rst_tx"}, tx, 1'b1);
        chk({name, "_rst_busy"}, busy, 1'b0);
        chk({name, "_rst_done"}, done, 1'b0);
        rst = 1'b1;
        step();
        return;
      end
      if (n < NB*CPB) step();
    end
    if (mode == 2) return;
    for (int n = 0; n < 2*CPB; n++) begin
      step();
      chk({name, "_post_tx"}, tx, 1'b1);
      chk({name, "_post_busy"}, busy, 1'b0);
      chk({name, "_post_done"}, done, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;
    step();

    run_frame("f55", 8'h55, 10'b1010101010, 1'b0, 0);
    run_frame("f30", 8'h30, 10'b1001100000, 1'b0, 1);
    run_frame("f31", 8'h31, 10'b1001100010, 1'b1, 2);
    run_frame("f0D", 8'h0D, 10'b1000011010, 1'b1, 0);
    run_frame("frst", 8'h5A, 10'b1010110100, 1'b0, 4);
    run_frame("fA5", 8'hA5, 10'b1101001010, 1'b0, 0);
`ifdef UART_TX_PARITY_EN
    run_frame("f07", 8'h07, 10'b1000001110, 1'b1, 0);
    run_frame("f03", 8'h03, 10'b1000000110, 1'b0, 0);
`endif

    // CLKS_PER_BIT=2, 0xFF: 2 cycles low then all ones (parity 0 when enabled).
    din2 = 8'hFF;
    en2  = 1'b1;
    step();
    en2  = 1'b0;
    for (int n = 0; n <= NB*2; n++) begin
      if (n < NB*2) begin
        chk($sformatf("c2_tx%0d", n), tx2,
            (n < 2 || (NB == 11 && n >= 18 && n < 20)) ? 1'b0 : 1'b1);
        chk($sformatf("c2_done%0d", n), done2, 1'b0);
      end else begin
        chk("c2_done_pulse", done2, 1'b1);
        chk("c2_done_busy", busy2, 1'b0);
      end
      if (n < NB*2) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
